// File: rtl/moving_average_pkg.sv
// Shared sizing helpers for the boxcar moving-average filter.
// Rounding helper is only referenced when MOVING_AVERAGE_ROUND_EN is defined.
package moving_average_pkg;

    localparam int MAX_LOG2_DEPTH = 6;

    // Accumulator width: DEPTH samples of DATA_W bits cannot exceed DATA_W+LOG2_DEPTH bits.
    function automatic int sum_width(input int data_w, input int log2_depth);
        return data_w + log2_depth;
    endfunction

    // Half an LSB of the divided result, added before the shift to round to nearest.
    function automatic int round_offset(input int log2_depth);
        return 1 << (log2_depth - 1);
    endfunction

endpackage

// File: rtl/moving_average_filter_p_ring.sv
// DEPTH x DATA_W sample ring with write pointer and synchronous clear.
// The oldest sample (the slot about to be overwritten) is presented combinationally.
module ma_sample_ring
    import moving_average_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LOG2_DEPTH = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] oldest
);
    localparam int DEPTH = 1 << LOG2_DEPTH;

    logic [DEPTH-1:0][DATA_W-1:0] ring_q;
    logic [LOG2_DEPTH-1:0]        wr_ptr;

    always_ff @(posedge clk) begin
        if (clr) begin
            ring_q <= '0;
            wr_ptr <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < DEPTH; i++)
                if (wr_ptr == LOG2_DEPTH'(i)) ring_q[i] <= wr_data;
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    assign oldest = ring_q[wr_ptr];

endmodule

// File: rtl/moving_average_filter_p.sv
// Parametrised boxcar moving-average filter with valid strobe, primed flag and fill count.
// Define MOVING_AVERAGE_ROUND_EN to round to nearest instead of truncating.
module moving_average_filter_p
    import moving_average_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LOG2_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_primed,
    output logic [LOG2_DEPTH:0]   fill_cnt
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = sum_width(DATA_W, LOG2_DEPTH);

    logic              flush, accept;
    logic [DATA_W-1:0] oldest, avg;
    logic [SUM_W-1:0]  sum_q, sum_next;
    logic [LOG2_DEPTH:0] fill_next;

    assign flush  = rst | clr_i;
    assign accept = in_valid & ~clr_i;

    ma_sample_ring #(.DATA_W(DATA_W), .LOG2_DEPTH(LOG2_DEPTH)) u_ring (
        .clk     (clk),
        .clr     (flush),
        .wr_en   (accept),
        .wr_data (in_data),
        .oldest  (oldest)
    );

    // The sample leaving the window is already part of sum_q, so this never underflows.
    assign sum_next  = sum_q + SUM_W'(in_data) - SUM_W'(oldest);
    assign fill_next = (fill_cnt == (LOG2_DEPTH+1)'(DEPTH)) ? fill_cnt : fill_cnt + 1'b1;

`ifdef MOVING_AVERAGE_ROUND_EN
    logic [SUM_W:0] rnd;
    logic           unused_rnd;
    assign rnd        = {1'b0, sum_next} + (SUM_W+1)'(round_offset(LOG2_DEPTH));
    assign avg        = rnd[SUM_W-1:LOG2_DEPTH];
    assign unused_rnd = &{1'b0, rnd[SUM_W], rnd[LOG2_DEPTH-1:0]};
`else
    assign avg = sum_next[SUM_W-1:LOG2_DEPTH];
`endif

    always_ff @(posedge clk) begin
        if (flush) begin
            sum_q      <= '0;
            fill_cnt   <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_primed <= 1'b0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                sum_q    <= sum_next;
                fill_cnt <= fill_next;
                out_data <= avg;
                if (fill_next == (LOG2_DEPTH+1)'(DEPTH)) out_primed <= 1'b1;
            end
        end
    end

endmodule
